// File: rtl/ext_bus_pkg.sv
// rtl/ext_bus_pkg.sv - byte-bus phase codes and bridge FSM state encoding
package ext_bus_pkg;

  localparam logic [1:0] PH_ADDR  = 2'b00;
  localparam logic [1:0] PH_WDATA = 2'b01;
  localparam logic [1:0] PH_RDATA = 2'b10;
  localparam logic [1:0] PH_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser for a single asynchronous level
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/ext_mem_bridge.sv
// rtl/ext_mem_bridge.sv - word request to four-phase handshaked byte-bus bridge
module ext_mem_bridge
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_done,
  output logic              err,
  output logic [7:0]        bus_out,
  input  logic [7:0]        bus_in,
  output logic [7:0]        bus_oe,
  output logic              stb,
  output logic [1:0]        phase,
  input  logic              ack_in
);

  localparam int NA = ADDR_W / 8;
  localparam int ND = DATA_W / 8;
  localparam int NB = NA + ND;
  localparam int CW = $clog2(NB) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_nx;
  logic              ack_s;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_shift;
  logic [CW-1:0]     byte_cnt;
  logic [CW-1:0]     data_idx;
  logic [TW-1:0]     tmo_cnt;
  logic              err_q;
  logic              accept, tmo_hit, addr_byte, last_byte;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_in),
    .q     (ack_s)
  );

  // The err cycle still counts as busy so a new request cannot race the abort.
  assign accept    = (state == ST_IDLE) && !err_q && req;
  assign busy      = (state != ST_IDLE) || err_q;
  assign err       = err_q;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT));
  assign addr_byte = (byte_cnt < CW'(NA));
  assign last_byte = (byte_cnt == CW'(NB - 1));
  assign data_idx  = byte_cnt - CW'(NA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stb      = 1'b0;
    bus_oe   = 8'h00;
    bus_out  = 8'h00;
    phase    = PH_IDLE;
    rd_valid = 1'b0;
    wr_done  = 1'b0;
    if (state inside {ST_SETUP, ST_STROBE, ST_RELEASE}) begin
      phase  = addr_byte ? PH_ADDR : (we_q ? PH_WDATA : PH_RDATA);
      bus_oe = (addr_byte || we_q) ? 8'hFF : 8'h00;
      if (addr_byte)  bus_out = 8'(addr_q >> {byte_cnt, 3'b000});
      else if (we_q)  bus_out = 8'(wdata_q >> {data_idx, 3'b000});
    end
    case (state)
      ST_IDLE:    if (accept) state_nx = ST_SETUP;
      ST_SETUP:   state_nx = ST_STROBE;
      ST_STROBE: begin
        stb = 1'b1;
        if (ack_s)        state_nx = ST_RELEASE;
        else if (tmo_hit) state_nx = ST_IDLE;
      end
      ST_RELEASE: begin
        if (!ack_s)       state_nx = last_byte ? ST_DONE : ST_SETUP;
        else if (tmo_hit) state_nx = ST_IDLE;
      end
      ST_DONE: begin
        rd_valid = !we_q;
        wr_done  = we_q;
        state_nx = ST_IDLE;
      end
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_shift <= '0;
      rd_data  <= '0;
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          we_q     <= req_we;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          byte_cnt <= '0;
          rd_shift <= '0;
        end
        ST_SETUP: tmo_cnt <= '0;
        ST_STROBE: begin
          if (ack_s) begin
            tmo_cnt <= '0;
            if (!addr_byte && !we_q)
              rd_shift <= rd_shift | (DATA_W'(bus_in) << {data_idx, 3'b000});
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_RELEASE: begin
          if (!ack_s) begin
            byte_cnt <= byte_cnt + CW'(1);
            // Publish the read word only once every byte has landed; an abort leaves rd_data alone.
            if (last_byte && !we_q) rd_data <= rd_shift;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_bridge.sv
// tb/tb_ext_mem_bridge.sv - randomized self-checking bench for ext_mem_bridge
module tb_ext_mem_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_a = 0, we_a = 0;
  logic [15:0] addr_a = 0, wdata_a = 0, rdd_a;
  logic        busy_a, rdv_a, wrd_a, err_a, stb_a;
  logic [7:0]  bo_a, oe_a, bi_a = 0;
  logic [1:0]  ph_a;
  logic        ack_a = 0;

  logic        req_b = 0, we_b = 0;
  logic [23:0] addr_b = 0;
  logic [31:0] wdata_b = 0, rdd_b;
  logic        busy_b, rdv_b, wrd_b, err_b, stb_b;
  logic [7:0]  bo_b, oe_b, bi_b = 0;
  logic [1:0]  ph_b;
  logic        ack_b = 0;

  ext_mem_bridge #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(10), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .req_we(we_a), .req_addr(addr_a),
    .req_wdata(wdata_a), .busy(busy_a), .rd_valid(rdv_a), .rd_data(rdd_a),
    .wr_done(wrd_a), .err(err_a), .bus_out(bo_a), .bus_in(bi_a), .bus_oe(oe_a),
    .stb(stb_a), .phase(ph_a), .ack_in(ack_a)
  );

  ext_mem_bridge #(.ADDR_W(24), .DATA_W(32), .TIMEOUT(10), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_we(we_b), .req_addr(addr_b),
    .req_wdata(wdata_b), .busy(busy_b), .rd_valid(rdv_b), .rd_data(rdd_b),
    .wr_done(wrd_b), .err(err_b), .bus_out(bo_b), .bus_in(bi_b), .bus_oe(oe_b),
    .stb(stb_b), .phase(ph_b), .ack_in(ack_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          cyc = 0;
  logic [17:0] log_a[$];
  int          rise_a[$];
  logic [7:0]  rq_a[$];
  int          done_a = 0, rdvc_a = 0, errc_a = 0;
  int          dly_a = 0, wcnt_a = 0;
  bit          silent_a = 0;
  logic        stb_prev_a = 0;
  logic [15:0] last_rd = 0;

  // Responder and monitor for dut_a: logs each strobe, acks after dly_a cycles.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      ack_a = 0; wcnt_a = 0; stb_prev_a = 0;
    end else begin
      if (stb_a && !stb_prev_a) begin
        log_a.push_back({ph_a, oe_a, bo_a});
        rise_a.push_back(cyc);
      end
      stb_prev_a = stb_a;
      if (wrd_a) done_a++;
      if (rdv_a) rdvc_a++;
      if (err_a) errc_a++;
      if (!silent_a) begin
        if (stb_a && !ack_a) begin
          if (wcnt_a >= dly_a) begin
            ack_a = 1; wcnt_a = 0;
            if (ph_a == 2'b10 && rq_a.size() > 0) bi_a = rq_a.pop_front();
          end else wcnt_a++;
        end else if (!stb_a && ack_a) begin
          if (wcnt_a >= dly_a) begin ack_a = 0; wcnt_a = 0; end
          else wcnt_a++;
        end
      end
    end
  end

  logic [17:0] log_b[$];
  logic [7:0]  rq_b[$];
  int          done_b = 0, rdvc_b = 0;
  logic        stb_prev_b = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ack_b = 0; stb_prev_b = 0;
    end else begin
      if (stb_b && !stb_prev_b) begin
        log_b.push_back({ph_b, oe_b, bo_b});
        if (ph_b == 2'b10 && rq_b.size() > 0) bi_b = rq_b.pop_front();
      end
      stb_prev_b = stb_b;
      ack_b = stb_b;
      if (wrd_b) done_b++;
      if (rdv_b) rdvc_b++;
    end
  end

  function automatic logic [17:0] exp_byte_a(input int i, input logic we,
                                             input logic [15:0] addr, input logic [15:0] wdata);
    if (i < 2)  return {2'b00, 8'hFF, 8'((addr >> (8 * i)) & 16'hFF)};
    if (we)     return {2'b01, 8'hFF, 8'((wdata >> (8 * (i - 2))) & 16'hFF)};
    return {2'b10, 8'h00, 8'h00};
  endfunction

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic run_txn_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rword, input int dly);
    int n, d0, r0, e0;
    logic [17:0] e;
    @(negedge clk);
    wait_idle_a();
    dly_a = dly;
    log_a.delete(); rise_a.delete(); rq_a.delete();
    rq_a.push_back(rword[7:0]);
    rq_a.push_back(rword[15:8]);
    d0 = done_a; r0 = rdvc_a; e0 = errc_a;
    req_a = 1; we_a = we; addr_a = addr; wdata_a = wdata;
    @(negedge clk);
    req_a = 0;
    chk("accept_busy", busy_a, 1);
    n = 0;
    while (busy_a && n < 2000) begin @(negedge clk); n++; end
    chk("txn_bound", (n < 2000), 1);
    @(negedge clk);
    if (!we) last_rd = rword;
    chk("wr_done_cnt", done_a - d0, we ? 1 : 0);
    chk("rd_valid_cnt", rdvc_a - r0, we ? 0 : 1);
    chk("err_cnt", errc_a - e0, 0);
    chk("rd_data", rdd_a, last_rd);
    chk("strobes", log_a.size(), 4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      e = exp_byte_a(i, we, addr, wdata);
      if (e[17:16] == 2'b10) chk("rd_byte_ph_oe", log_a[i][17:8], e[17:8]);
      else                   chk("byte", log_a[i], e);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, k, t, d0, r0, e0, acc;
    logic prev;
    logic [15:0] a16, w16;
    logic [17:0] e;

    repeat (3) @(negedge clk);
    chk("rst_outs_a", {stb_a, oe_a, bo_a, ph_a, busy_a, rdv_a, wrd_a, err_a},
        {1'b0, 8'h00, 8'h00, 2'b11, 4'b0000});
    chk("rst_rd_data_a", rdd_a, 0);
    chk("rst_outs_b", {stb_b, oe_b, ph_b, busy_b}, {1'b0, 8'h00, 2'b11, 1'b0});
    rst_n = 1;
    @(negedge clk);

    run_txn_a(1, 16'h1234, 16'hBEEF, 16'h0000, 0);
    if (rise_a.size() >= 2) chk("byte_time", rise_a[1] - rise_a[0], 7);
    else chk("byte_time_rises", rise_a.size(), 2);

    run_txn_a(0, 16'h0040, 16'h0000, 16'hC35A, 0);
    chk("read_c35a", rdd_a, 16'hC35A);

    for (int i = 0; i < 16; i++)
      run_txn_a(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                16'($urandom), $urandom_range(0, 3));

    // Silent responder: abort on first address byte.
    @(negedge clk);
    wait_idle_a();
    silent_a = 1; e0 = errc_a; d0 = done_a; r0 = rdvc_a;
    req_a = 1; we_a = 0; addr_a = 16'h0777;
    @(negedge clk);
    req_a = 0;
    n = 0;
    while (!stb_a && n < 20) begin @(negedge clk); n++; end
    t = 0;
    while (!err_a && t < 40) begin @(negedge clk); t++; end
    chk("err_latency", t, 11);
    chk("err_stb", stb_a, 0);
    @(negedge clk);
    chk("post_err", {stb_a, busy_a, oe_a}, {1'b0, 1'b0, 8'h00});
    chk("post_err_rd_data", rdd_a, last_rd);
    chk("err_pulses", errc_a - e0, 1);
    chk("err_no_done", (done_a - d0) + (rdvc_a - r0), 0);
    silent_a = 0;

    // Reset during the second address byte strobe.
    dly_a = 0;
    wait_idle_a();
    req_a = 1; we_a = 1; addr_a = 16'hA5C3; wdata_a = 16'h0F0F;
    @(negedge clk);
    req_a = 0;
    prev = 0; k = 0; n = 0;
    while (k < 2 && n < 100) begin
      @(negedge clk); n++;
      if (stb_a && !prev) k++;
      prev = stb_a;
    end
    chk("rst_mid_reached", k, 2);
    rst_n = 0;
    #1;
    chk("rst_mid_outs", {stb_a, oe_a, bo_a, ph_a, busy_a, rdv_a, wrd_a, err_a},
        {1'b0, 8'h00, 8'h00, 2'b11, 4'b0000});
    chk("rst_mid_rd_data", rdd_a, 0);
    last_rd = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    d0 = done_a; r0 = rdvc_a; e0 = errc_a;
    repeat (6) @(negedge clk);
    chk("rst_no_pulse", (done_a - d0) + (rdvc_a - r0) + (errc_a - e0), 0);
    run_txn_a(1, 16'h2468, 16'h9BDF, 16'h0000, 1);

    // req held high: back-to-back writes.
    @(negedge clk);
    wait_idle_a();
    dly_a = 0; log_a.delete(); d0 = done_a;
    a16 = 16'h5A17; w16 = 16'hE39C;
    req_a = 1; we_a = 1; addr_a = a16; wdata_a = w16;
    prev = 0; acc = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy_a && !prev) acc++;
      prev = busy_a;
    end
    req_a = 0;
    n = 0;
    while (busy_a && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("b2b_min_txns", (acc >= 3), 1);
    chk("b2b_done", done_a - d0, acc);
    chk("b2b_strobes", log_a.size(), 4 * acc);
    for (int i = 0; i < log_a.size(); i++) begin
      e = exp_byte_a(i % 4, 1'b1, a16, w16);
      chk("b2b_byte", log_a[i], e);
    end

    // 24-bit address, 32-bit data instance.
    log_b.delete(); d0 = done_b;
    req_b = 1; we_b = 1; addr_b = 24'hABCDEF; wdata_b = 32'h01020304;
    @(negedge clk);
    req_b = 0;
    n = 0;
    while (busy_b && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("b_wr_done", done_b - d0, 1);
    chk("b_strobes", log_b.size(), 7);
    for (int i = 0; i < 7 && i < log_b.size(); i++) begin
      if (i < 3) e = {2'b00, 8'hFF, 8'((addr_b >> (8 * i)) & 24'hFF)};
      else       e = {2'b01, 8'hFF, 8'((wdata_b >> (8 * (i - 3))) & 32'hFF)};
      chk("b_byte", log_b[i], e);
    end

    log_b.delete(); r0 = rdvc_b;
    rq_b = '{8'hEF, 8'hCD, 8'hAB, 8'h89};
    req_b = 1; we_b = 0; addr_b = 24'h000100;
    @(negedge clk);
    req_b = 0;
    n = 0;
    while (busy_b && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("b_rd_valid", rdvc_b - r0, 1);
    chk("b_rd_data", rdd_b, 32'h89ABCDEF);
    if (log_b.size() == 7) chk("b_rd_oe", log_b[5][15:8], 8'h00);
    else chk("b_rd_strobes", log_b.size(), 7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
